// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA display generator:
//   - mode_e        : test-pattern select encodings
//   - MASK_*        : 3-bit {R,G,B} masks of the eight colour bars
//   - DEF_*         : default 640x480@60 timing constants
//   - h_total/v_total : total line / frame length from the four timing params
//   - bar_mask      : bar index -> {R,G,B} mask
//   - expand_bit    : replicate a 1-bit channel mask to c bits (low bits)
// ---------------------------------------------------------------------------
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_BAR      = 2'd0,
        MODE_CHECKER  = 2'd1,
        MODE_GRADIENT = 2'd2,
        MODE_SOLID    = 2'd3
    } mode_e;

    localparam logic [2:0] MASK_WHITE   = 3'b111;
    localparam logic [2:0] MASK_YELLOW  = 3'b110;
    localparam logic [2:0] MASK_CYAN    = 3'b011;
    localparam logic [2:0] MASK_GREEN   = 3'b010;
    localparam logic [2:0] MASK_MAGENTA = 3'b101;
    localparam logic [2:0] MASK_RED     = 3'b100;
    localparam logic [2:0] MASK_BLUE    = 3'b001;
    localparam logic [2:0] MASK_BLACK   = 3'b000;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    function automatic logic [2:0] bar_mask(input logic [2:0] idx);
        case (idx)
            3'd0:    return MASK_WHITE;
            3'd1:    return MASK_YELLOW;
            3'd2:    return MASK_CYAN;
            3'd3:    return MASK_GREEN;
            3'd4:    return MASK_MAGENTA;
            3'd5:    return MASK_RED;
            3'd6:    return MASK_BLUE;
            default: return MASK_BLACK;
        endcase
    endfunction

    // Result has the low c bits equal to b, upper bits zero (c < 32).
    function automatic logic [31:0] expand_bit(input logic b, input int unsigned c);
        return b ? ((32'd1 << c) - 32'd1) : 32'd0;
    endfunction

endpackage

// File: rtl/vga_pattern.sv
// ---------------------------------------------------------------------------
// vga_pattern
// Combinational test-pattern source: (x', y, mode, solid) -> colour.
// Ports:
//   i_x     [XW-1:0]    horizontal active coordinate (already scrolled)
//   i_y5                bit 5 of the vertical active coordinate (the only
//                       bit of y any pattern depends on)
//   i_mode  mode_e      pattern select
//   i_solid [RGB_W-1:0] colour for the solid pattern
//   o_rgb   [RGB_W-1:0] colour, {R,G,B}
// ---------------------------------------------------------------------------
module vga_pattern
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned RGB_W    = 12,
    parameter int unsigned XW       = 10
) (
    input  logic [XW-1:0]    i_x,
    input  logic             i_y5,
    input  mode_e            i_mode,
    input  logic [RGB_W-1:0] i_solid,
    output logic [RGB_W-1:0] o_rgb
);

    localparam int unsigned C     = RGB_W / 3;
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    logic [2:0] w_mask;
    logic       w_x5;

    always_comb begin
        w_mask = bar_mask(3'(32'(i_x) / BAR_W));
        w_x5   = 1'(32'(i_x) >> 5);
        o_rgb  = '0;
        case (i_mode)
            MODE_BAR:      o_rgb = {C'(expand_bit(w_mask[2], C)),
                                    C'(expand_bit(w_mask[1], C)),
                                    C'(expand_bit(w_mask[0], C))};
            MODE_CHECKER:  o_rgb = (w_x5 ^ i_y5) ? '0 : '1;
            MODE_GRADIENT: o_rgb = {3{i_x[XW-1 -: C]}};
            MODE_SOLID:    o_rgb = i_solid;
            default:       o_rgb = '0;
        endcase
    end

endmodule

// File: rtl/vga_display_gen.sv
// ---------------------------------------------------------------------------
// vga_display_gen
// Single-clock VGA display generator: clock-enable divider, h/v timing
// counters, sync decode, test-pattern source and a registered output stage
// that keeps sync, de, colour, coordinates and frame_start aligned.
// Optional feature macro: VGA_SCROLL_EN (horizontal scroll, one pixel per
// frame, for the bar/checker/gradient patterns).
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   mode_i [1:0]                pattern select (latched at pixel (0,0))
//   solid_i [RGB_W-1:0]         solid colour (latched at pixel (0,0))
//   hsync, vsync                syncs, active level HS_POL / VS_POL
//   de                          active-video enable
//   rgb [RGB_W-1:0]             pixel colour {R,G,B}, 0 in blanking
//   pix_x, pix_y [9:0]          coordinate of the presented pixel, 0 in blanking
//   frame_start                 one-clk pulse when pixel (0,0) is presented
// ---------------------------------------------------------------------------
module vga_display_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned RGB_W    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode_i,
    input  logic [RGB_W-1:0] solid_i,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [RGB_W-1:0] rgb,
    output logic [9:0]       pix_x,
    output logic [9:0]       pix_y,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned XW      = $clog2(H_ACTIVE);
    localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DW-1:0]    r_div;
    logic [HW-1:0]    r_h_cnt;
    logic [VW-1:0]    r_v_cnt;
    mode_e            r_mode;
    logic [RGB_W-1:0] r_solid;

    logic             w_pe, w_first, w_active, w_hs_on, w_vs_on;
    logic             w_h_last, w_v_last, w_y5;
    mode_e            w_mode;
    logic [RGB_W-1:0] w_solid, w_color;
    logic [XW-1:0]    w_x, w_xp;

`ifdef VGA_SCROLL_EN
    logic [XW-1:0]    r_x_off;
    logic [XW:0]      w_x_sum;
    localparam logic [XW:0] H_ACT_X = (XW+1)'(H_ACTIVE);
`endif

    always_comb begin
        w_pe     = (CLK_DIV == 1) ? 1'b1 : (r_div == DIV_LAST);
        w_h_last = (r_h_cnt == H_LAST);
        w_v_last = (r_v_cnt == V_LAST);
        w_first  = (r_h_cnt == '0) && (r_v_cnt == '0);
        w_active = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
        w_hs_on  = (r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST);
        w_vs_on  = (r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST);
        // Pixel (0,0) already uses the inputs it latches, so a new mode
        // covers the whole frame.
        w_mode   = w_first ? mode_e'(mode_i) : r_mode;
        w_solid  = w_first ? solid_i : r_solid;
        w_x      = r_h_cnt[XW-1:0];
        w_y5     = 1'(32'(r_v_cnt) >> 5);
`ifdef VGA_SCROLL_EN
        w_x_sum  = {1'b0, w_x} + {1'b0, r_x_off};
        w_xp     = (w_x_sum >= H_ACT_X) ? XW'(w_x_sum - H_ACT_X) : w_x_sum[XW-1:0];
`else
        w_xp     = w_x;
`endif
    end

    vga_pattern #(
        .H_ACTIVE (H_ACTIVE),
        .RGB_W    (RGB_W),
        .XW       (XW)
    ) u_pattern (
        .i_x     (w_xp),
        .i_y5    (w_y5),
        .i_mode  (w_mode),
        .i_solid (w_solid),
        .o_rgb   (w_color)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div       <= '0;
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_mode      <= MODE_BAR;
            r_solid     <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            rgb         <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
        end else begin
            // frame_start marks only the first clk of the (0,0) pixel period.
            frame_start <= 1'b0;
            if (w_pe) begin
                r_div <= '0;
                if (w_h_last) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
                end else begin
                    r_h_cnt <= r_h_cnt + HW'(1);
                end
                if (w_first) begin
                    r_mode  <= mode_e'(mode_i);
                    r_solid <= solid_i;
                end
                hsync       <= w_hs_on ? HS_POL : ~HS_POL;
                vsync       <= w_vs_on ? VS_POL : ~VS_POL;
                de          <= w_active;
                rgb         <= w_active ? w_color : '0;
                pix_x       <= w_active ? 10'(r_h_cnt) : '0;
                pix_y       <= w_active ? 10'(r_v_cnt) : '0;
                frame_start <= w_first;
            end else begin
                r_div <= r_div + DW'(1);
            end
        end
    end

`ifdef VGA_SCROLL_EN
    // Offset advances at the frame wrap, so frame n after reset uses offset n.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x_off <= '0;
        end else if (w_pe && w_h_last && w_v_last) begin
            r_x_off <= (32'(r_x_off) == H_ACTIVE - 1) ? '0 : r_x_off + XW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_vga_display_gen.sv
module tb_vga_display_gen;

    localparam int unsigned HA = 48, HFP = 2, HSY = 4, HBP = 2;
    localparam int unsigned VA = 34, VFP = 1, VSY = 2, VBP = 1;
    localparam int unsigned D  = 2;
    localparam int unsigned HT = HA + HFP + HSY + HBP;
    localparam int unsigned VT = VA + VFP + VSY + VBP;
    localparam int unsigned FRAME = HT * VT;
    localparam int unsigned XW = $clog2(HA);
    localparam int unsigned LIMIT = 3 * FRAME * D;

    localparam logic [11:0] BAR_RGB [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                             12'hF0F, 12'hF00, 12'h00F, 12'h000};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode_i = 2'd0;
    logic [11:0] solid_i = 12'h000;
    logic        hsync, vsync, de, frame_start;
    logic [11:0] rgb;
    logic [9:0]  pix_x, pix_y;

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;

    vga_display_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
        .HS_POL (1'b0), .VS_POL (1'b0), .CLK_DIV (D), .RGB_W (12)
    ) dut (
        .clk (clk), .rst_n (rst_n), .mode_i (mode_i), .solid_i (solid_i),
        .hsync (hsync), .vsync (vsync), .de (de), .rgb (rgb),
        .pix_x (pix_x), .pix_y (pix_y), .frame_start (frame_start)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic timed_out(input string name);
        n_chk++;
        $display("FAIL %s: event not seen within %0d cycles, required it to occur", name, LIMIT);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [11:0] ref_color(input int unsigned mode, input int unsigned x,
                                              input int unsigned y, input logic [11:0] solid);
        int unsigned g;
        case (mode)
            0: return BAR_RGB[x / (HA / 8)];
            1: return (((x / 32) % 2) == ((y / 32) % 2)) ? 12'hFFF : 12'h000;
            2: begin
                g = (x * 16) >> XW;
                return 12'(g * 12'h111);
            end
            default: return solid;
        endcase
    endfunction

    int unsigned m_c = 0;
    bit          m_on = 1'b0;
    int unsigned m_mode = 0;
    logic [11:0] m_solid = 12'h000;

    // m_c = clk edges since the last edge that saw reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_c  <= 0;
            m_on <= 1'b1;
        end else if (m_on) begin
            m_c <= m_c + 1;
            if (((m_c + 1) % D == 0) && ((((m_c + 1) / D) - 1) % FRAME == 0)) begin
                m_mode  <= int'(mode_i);
                m_solid <= solid_i;
            end
        end
    end

    always @(negedge clk) begin : scoreboard
        int unsigned k, h, v, f, xp;
        logic e_hs, e_vs, e_de, e_fs;
        logic [11:0] e_rgb;
        logic [9:0] e_px, e_py;
        if (m_on) begin
            if (m_c < D) begin
                {e_hs, e_vs, e_de, e_fs, e_rgb, e_px, e_py} = {1'b1, 1'b1, 1'b0, 1'b0, 12'h0, 10'h0, 10'h0};
            end else begin
                k = m_c / D - 1;
                h = k % HT;
                v = (k / HT) % VT;
                f = k / FRAME;
`ifdef VGA_SCROLL_EN
                xp = (h + f) % HA;
`else
                xp = h;
`endif
                e_de  = (h < HA) && (v < VA);
                e_hs  = !((h >= HA + HFP) && (h < HA + HFP + HSY));
                e_vs  = !((v >= VA + VFP) && (v < VA + VFP + VSY));
                e_fs  = (m_c % D == 0) && (h == 0) && (v == 0);
                e_rgb = e_de ? ref_color(m_mode, xp, v, m_solid) : 12'h000;
                e_px  = e_de ? 10'(h) : 10'd0;
                e_py  = e_de ? 10'(v) : 10'd0;
            end
            check("scoreboard{hs,vs,de,fs,rgb,x,y}",
                  {hsync, vsync, de, frame_start, rgb, pix_x, pix_y},
                  {e_hs, e_vs, e_de, e_fs, e_rgb, e_px, e_py});
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_fs(input string name);
        int unsigned n = 0;
        @(negedge clk);
        while (!frame_start && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!frame_start) timed_out(name);
    endtask

    task automatic wait_pix(input int unsigned x, input int unsigned y, input string name);
        int unsigned n = 0;
        while (!(de && pix_x == x && pix_y == y) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!(de && pix_x == x && pix_y == y)) timed_out(name);
    endtask

    // Reset held across one edge; returns right after the first pixel appears.
    task automatic reset_pulse(input string name);
        rst_n = 1'b0;
        @(negedge clk);
        check({name, "_state"}, {hsync, vsync, de, frame_start, rgb, pix_x, pix_y},
              {1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 10'd0, 10'd0});
        rst_n = 1'b1;
        @(negedge clk);
        check({name, "_edge1_de"}, {de, frame_start}, 2'b00);
        @(negedge clk);
        check({name, "_first_pixel"}, {de, frame_start, pix_x, pix_y}, {1'b1, 1'b1, 10'd0, 10'd0});
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [11:0] solid;
        int unsigned x;
        int unsigned y;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl [17];

    initial begin : watchdog
        #(2_000_000 * 10);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : main
        int unsigned cyc, nde, nhs, nvs;

        tbl[0]  = '{2'd0, 12'h000,  0,  0, 12'hFFF};
        tbl[1]  = '{2'd0, 12'h000, 36,  1, 12'h00F};
        tbl[2]  = '{2'd0, 12'h000,  6,  3, 12'hFF0};
        tbl[3]  = '{2'd0, 12'h000, 14,  7, 12'h0FF};
        tbl[4]  = '{2'd0, 12'h000, 47, 10, 12'h000};
        tbl[5]  = '{2'd0, 12'h000, 30, 20, 12'hF00};
        tbl[6]  = '{2'd0, 12'h000, 42, 33, 12'h000};
        tbl[7]  = '{2'd1, 12'h000,  0,  0, 12'hFFF};
        tbl[8]  = '{2'd1, 12'h000, 32,  0, 12'h000};
        tbl[9]  = '{2'd1, 12'h000,  0, 32, 12'h000};
        tbl[10] = '{2'd1, 12'h000, 32, 32, 12'hFFF};
        tbl[11] = '{2'd2, 12'h000,  4,  1, 12'h111};
        tbl[12] = '{2'd2, 12'h000,  7,  1, 12'h111};
        tbl[13] = '{2'd2, 12'h000, 32,  5, 12'h888};
        tbl[14] = '{2'd2, 12'h000, 47,  9, 12'hBBB};
        tbl[15] = '{2'd3, 12'h0F0, 20, 20, 12'h0F0};
        tbl[16] = '{2'd3, 12'hA5C,  5,  5, 12'hA5C};

        // Reset defaults and first pixel latency
        repeat (10) @(negedge clk);
        check("reset_state", {hsync, vsync, de, frame_start, rgb, pix_x, pix_y},
              {1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 10'd0, 10'd0});
        rst_n = 1'b1;
        @(negedge clk);
        check("no_output_at_edge1", {de, frame_start, rgb}, {1'b0, 1'b0, 12'h000});
        @(negedge clk);
        check("first_pixel_at_edge2", {de, frame_start, rgb, pix_x, pix_y},
              {1'b1, 1'b1, 12'hFFF, 10'd0, 10'd0});
        @(negedge clk);
        check("frame_start_one_clk", {frame_start, de, rgb}, {1'b0, 1'b1, 12'hFFF});

        // Frame-level timing over one full frame
        wait_fs("frame_measure_start");
        cyc = 0; nde = 0; nhs = 0; nvs = 0;
        do begin
            nde += int'(de);
            nhs += int'(!hsync);
            nvs += int'(!vsync);
            @(negedge clk);
            cyc++;
        end while (!frame_start && cyc < LIMIT);
        check("frame_interval_clk", 64'(cyc), 64'(FRAME * D));
        check("de_high_clk", 64'(nde), 64'(HA * VA * D));
        check("hsync_low_clk", 64'(nhs), 64'(VT * HSY * D));
        check("vsync_low_clk", 64'(nvs), 64'(VSY * HT * D));

`ifndef VGA_SCROLL_EN
        // Pattern table
        for (int i = 0; i < 17; i++) begin
            if (tbl[i].mode != mode_i || tbl[i].solid != solid_i) begin
                mode_i  = tbl[i].mode;
                solid_i = tbl[i].solid;
                wait_fs("tbl_mode_latch");
            end
            wait_pix(tbl[i].x, tbl[i].y, "tbl_pixel");
            check($sformatf("tbl[%0d]_m%0d_(%0d,%0d)", i, tbl[i].mode, tbl[i].x, tbl[i].y),
                  64'(rgb), 64'(tbl[i].exp));
        end

        // Mid-frame mode change only takes effect next frame
        mode_i = 2'd0; solid_i = 12'h000;
        wait_fs("midframe_setup");
        wait_pix(0, 10, "midframe_line10");
        mode_i = 2'd3; solid_i = 12'h0F0;
        wait_pix(10, 20, "midframe_old_pixel");
        check("midframe_keeps_bar", 64'(rgb), 64'(12'hFF0));
        wait_fs("midframe_next");
        wait_pix(10, 5, "next_frame_pixel");
        check("next_frame_solid_a", 64'(rgb), 64'(12'h0F0));
        wait_pix(47, 33, "next_frame_last");
        check("next_frame_solid_b", 64'(rgb), 64'(12'h0F0));
`endif

        // Randomised mode/colour changes, checked by the scoreboard
        for (int i = 0; i < int'(2 * FRAME * D); i++) begin
            @(negedge clk);
            if ($urandom_range(0, 399) == 0) begin
                mode_i  = 2'($urandom_range(0, 3));
                solid_i = 12'($urandom);
            end
        end

        // Reset in the middle of a frame
        mode_i = 2'd0;
        wait_fs("pre_reset_frame");
        wait_pix(0, 15, "pre_reset_line");
        reset_pulse("midframe_reset");
        check("restart_white", 64'(rgb), 64'(12'hFFF));

`ifdef VGA_SCROLL_EN
        wait_pix(5, 0, "scroll_f0");
        check("scroll_f0_x5_white", 64'(rgb), 64'(12'hFFF));
        wait_fs("scroll_f1_start");
        wait_pix(5, 0, "scroll_f1");
        check("scroll_f1_x5_yellow", 64'(rgb), 64'(12'hFF0));
        wait_pix(0, 12, "scroll_pre_reset");
        reset_pulse("scroll_reset");
        wait_pix(5, 0, "scroll_after_reset");
        check("scroll_reset_x5_white", 64'(rgb), 64'(12'hFFF));
`endif

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
